// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles every bus signal of the write-back arbiter: the ALU result request,
// the LSU result handshake, the register-file write port and the hazard
// query/pending pair.
//   master : drives alu_*/lsu_* requests and queries, observes stall/ready,
//            the register-file write and the pending flags.
//   slave  : the arbiter side (the mirror of master).
// -----------------------------------------------------------------------------
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;

  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;

  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;

  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        pending1;
  logic        pending2;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  reg_write, write_register, write_data,
    output query_rs1, query_rs2,
    input  pending1, pending2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output reg_write, write_register, write_data,
    input  query_rs1, query_rs2,
    output pending1, pending2
  );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges the single-cycle ALU result stream and the buffered LSU result stream
// onto the one register-file write port, and reports which registers still
// have a write queued or outgoing.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-high; clears every queued/outgoing write
//   bus    : wb_arbiter_if.slave
//            alu_valid/alu_rd/alu_data in, alu_stall out (registered)
//            lsu_valid/lsu_rd/lsu_data in, lsu_ready out (from registered count)
//            reg_write/write_register/write_data out (registered)
//            query_rs1/query_rs2 in, pending1/pending2 out (combinational)
//
// Parameters:
//   DEPTH        : LSU FIFO entries, power of two, >= 2
//   STARVE_LIMIT : FIFO-head losses to the ALU before the ALU is stalled, 1..15
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> an LSU result may go straight to the output stage when the
//                port is idle and the FIFO is empty
//   undefined -> every LSU result passes through the FIFO
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic      clk,
  input  logic      reset,
  wb_arbiter_if.slave bus
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]      LIMIT_C = 4'(STARVE_LIMIT);

  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [4:0]       fifo_rd_d   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_data_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             alu_stall_q, alu_stall_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       write_register_q, write_register_d;
  logic [31:0]      write_data_q, write_data_d;

  logic             fifo_empty, lsu_ready;
  logic             alu_win, fifo_win, bypass_win, push;
  logic             win_valid;
  logic [4:0]       win_rd;
  logic [31:0]      win_data;
  logic             pend1, pend2;
  logic [PTR_W-1:0] idx;

  // Arbitration: a stalled ALU is ignored, so the FIFO head wins whenever the
  // ALU does not; bypass only when nothing else claims the port.
  always_comb begin
    fifo_empty = (count_q == {CNT_W{1'b0}});
    lsu_ready  = (count_q < DEPTH_C);
    alu_win    = !alu_stall_q && bus.alu_valid;
    fifo_win   = !fifo_empty && !alu_win;
`ifdef WB_BYPASS_EN
    bypass_win = fifo_empty && !alu_win && bus.lsu_valid;
`else
    bypass_win = 1'b0;
`endif
    push = bus.lsu_valid && lsu_ready && !bypass_win;
    if (alu_win) begin
      win_valid = 1'b1;
      win_rd    = bus.alu_rd;
      win_data  = bus.alu_data;
    end else if (fifo_win) begin
      win_valid = 1'b1;
      win_rd    = fifo_rd_q[rptr_q];
      win_data  = fifo_data_q[rptr_q];
    end else if (bypass_win) begin
      win_valid = 1'b1;
      win_rd    = bus.lsu_rd;
      win_data  = bus.lsu_data;
    end else begin
      win_valid = 1'b0;
      win_rd    = 5'd0;
      win_data  = 32'd0;
    end
  end

  // Next-state: FIFO storage/pointers, starvation counter, stall and output stage.
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (push) begin
      fifo_rd_d[wptr_q]   = bus.lsu_rd;
      fifo_data_d[wptr_q] = bus.lsu_data;
      wptr_d              = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (fifo_win) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push, fifo_win})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Counter only advances while the head is waiting behind an ALU win.
    if (fifo_empty || fifo_win) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    // One head drain per stall episode: the win itself ends the stall.
    if (fifo_win) begin
      alu_stall_d = 1'b0;
    end else if (starve_d == LIMIT_C) begin
      alu_stall_d = 1'b1;
    end else begin
      alu_stall_d = alu_stall_q;
    end
    // rd=0 is consumed like any winner but never reaches the register file.
    reg_write_d      = win_valid && (win_rd != 5'd0);
    write_register_d = win_rd;
    write_data_d     = win_data;
  end

  // Pending flags: any live FIFO entry or the outgoing write targeting the query.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    idx   = rptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx   = rptr_q + PTR_W'(k);
      pend1 = pend1 | ((CNT_W'(k) < count_q) && (fifo_rd_q[idx] == bus.query_rs1));
      pend2 = pend2 | ((CNT_W'(k) < count_q) && (fifo_rd_q[idx] == bus.query_rs2));
    end
    pend1 = (pend1 | (reg_write_q && (write_register_q == bus.query_rs1))) && (bus.query_rs1 != 5'd0);
    pend2 = (pend2 | (reg_write_q && (write_register_q == bus.query_rs2))) && (bus.query_rs2 != 5'd0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
      wptr_q           <= {PTR_W{1'b0}};
      rptr_q           <= {PTR_W{1'b0}};
      count_q          <= {CNT_W{1'b0}};
      starve_q         <= 4'd0;
      alu_stall_q      <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
    end else begin
      fifo_rd_q        <= fifo_rd_d;
      fifo_data_q      <= fifo_data_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      count_q          <= count_d;
      starve_q         <= starve_d;
      alu_stall_q      <= alu_stall_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign bus.alu_stall      = alu_stall_q;
  assign bus.lsu_ready      = lsu_ready;
  assign bus.reg_write      = reg_write_q;
  assign bus.write_register = write_register_q;
  assign bus.write_data     = write_data_q;
  assign bus.pending1       = pend1;
  assign bus.pending2       = pend2;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed stimulus for wb_arbiter with a queue-based reference model that is
// compared against every output on every cycle, plus literal expectations at
// the interesting points (reset, ALU write, starvation stall, full FIFO,
// pointer wrap ordering, pending flags, LSU latency).
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  wr_t         mq[$];
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_starve;
  bit          m_stall;

  int  tests = 0;
  int  fails = 0;
  wr_t log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (m_rw && m_wr == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one clock edge (or an asynchronous reset) to the model.
  task automatic model_step();
    bit  empty, ready, alu_w, fifo_w, byp, have;
    wr_t win;
    if (reset) begin
      mq.delete();
      m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
      m_starve = 0; m_stall = 1'b0;
      return;
    end
    empty  = (mq.size() == 0);
    ready  = (mq.size() < DEPTH);
    alu_w  = !m_stall && bus.alu_valid;
    fifo_w = !empty && !alu_w;
    byp    = BYP && empty && !alu_w && bus.lsu_valid;
    have   = alu_w || fifo_w || byp;
    if (alu_w)       win = '{rd: bus.alu_rd, data: bus.alu_data};
    else if (fifo_w) win = mq[0];
    else             win = '{rd: bus.lsu_rd, data: bus.lsu_data};
    m_rw = have && (win.rd != 5'd0);
    m_wr = win.rd;
    m_wd = win.data;
    if (empty || fifo_w) m_starve = 0;
    else                 m_starve++;
    m_stall = !fifo_w && (m_stall || m_starve == LIMIT);
    if (fifo_w) void'(mq.pop_front());
    if (bus.lsu_valid && ready && !byp) mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    chk("reg_write", bus.reg_write, m_rw);
    if (m_rw) begin
      chk("write_register", bus.write_register, m_wr);
      chk("write_data", bus.write_data, m_wd);
    end
    chk("alu_stall", bus.alu_stall, m_stall);
    chk("lsu_ready", bus.lsu_ready, (mq.size() < DEPTH));
    chk("pending1", bus.pending1, m_pend(bus.query_rs1));
    chk("pending2", bus.pending2, m_pend(bus.query_rs2));
    if (bus.reg_write && bus.write_register >= 5'd10 && bus.write_register < 5'd20)
      log_q.push_back('{rd: bus.write_register, data: bus.write_data});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    bit accepted;
    reset = 1'b1;
    idle_inputs();
    bus.query_rs1 = 5'd0;
    bus.query_rs2 = 5'd0;
    tick(); tick();
    // reset state
    chk("rst_reg_write", bus.reg_write, 1'b0);
    chk("rst_write_register", bus.write_register, 5'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_alu_stall", bus.alu_stall, 1'b0);
    chk("rst_lsu_ready", bus.lsu_ready, 1'b1);
    chk("rst_pending1", bus.pending1, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_reg_write", bus.reg_write, 1'b0);

    // ALU write rd=5, then asynchronous reset while it is outgoing
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk("alu_wr_rw", bus.reg_write, 1'b1);
    chk("alu_wr_rd", bus.write_register, 5'd5);
    chk("alu_wr_data", bus.write_data, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    model_step();
    chk("async_rst_rw", bus.reg_write, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // ALU rd=0 is consumed but not written
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    tick();
    idle_inputs();
    chk("alu_rd0_rw", bus.reg_write, 1'b0);
    tick();

    // Four LSU pushes under continuous ALU traffic -> full FIFO and stall
    for (int i = 0; i < 4; i++) begin
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(i + 1); bus.lsu_data = 32'(8'h11 * (i + 1));
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = 32'hA000 + 32'(i);
      tick();
    end
    chk("full_lsu_ready", bus.lsu_ready, 1'b0);
    chk("starve_stall", bus.alu_stall, 1'b1);
    bus.lsu_rd = 5'd5; bus.lsu_data = 32'h55;   // held while full, ALU held while stalled
    tick();
    chk("drain_rw", bus.reg_write, 1'b1);
    chk("drain_rd", bus.write_register, 5'd1);
    chk("drain_data", bus.write_data, 32'h11);
    chk("drain_stall_clear", bus.alu_stall, 1'b0);
    chk("pop_ready", bus.lsu_ready, 1'b1);
    bus.alu_rd = 5'd24; bus.alu_data = 32'hA004;
    tick();
    chk("refull_ready", bus.lsu_ready, 1'b0);
    idle_inputs();
    repeat (8) tick();

    // Pointer wrap: ten entries behind continuous ALU traffic, order preserved
    log_q.delete();
    idx = 0;
    for (int c = 0; c < 200 && idx < 10; c++) begin
      if (!bus.alu_stall) begin
        bus.alu_rd = 5'(20 + c % 4); bus.alu_data = 32'hB000 + 32'(c);
      end
      bus.alu_valid = 1'b1;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(10 + idx); bus.lsu_data = 32'h100 + 32'(idx);
      accepted = bus.lsu_ready;
      tick();
      if (accepted) idx++;
    end
    chk("wrap_accepted", idx, 10);
    idle_inputs();
    repeat (12) tick();
    chk("wrap_count", log_q.size(), 10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      chk("wrap_order_rd", log_q[i].rd, 10 + i);
      chk("wrap_order_data", log_q[i].data, 32'h100 + 32'(i));
    end

    // Pending flags for rd=7
    bus.query_rs1 = 5'd7; bus.query_rs2 = 5'd0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_data = 32'hC0;
    tick();
    idle_inputs();
    chk("pend_fifo_p1", bus.pending1, 1'b1);
    chk("pend_zero_p2", bus.pending2, 1'b0);
    bus.query_rs2 = 5'd7;
    tick();
    chk("pend_out_rw", bus.reg_write, 1'b1);
    chk("pend_out_rd", bus.write_register, 5'd7);
    chk("pend_out_p1", bus.pending1, 1'b1);
    chk("pend_out_p2", bus.pending2, 1'b1);
    tick();
    chk("pend_gone_p1", bus.pending1, 1'b0);
    chk("pend_gone_p2", bus.pending2, 1'b0);
    bus.query_rs1 = 5'd0; bus.query_rs2 = 5'd0;
    repeat (2) tick();

    // LSU latency on an idle port
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    tick();
    idle_inputs();
`ifdef WB_BYPASS_EN
    chk("lsu_lat_rw", bus.reg_write, 1'b1);
    chk("lsu_lat_rd", bus.write_register, 5'd9);
    chk("lsu_lat_data", bus.write_data, 32'h99);
`else
    chk("lsu_lat_early", bus.reg_write, 1'b0);
    tick();
    chk("lsu_lat_rw", bus.reg_write, 1'b1);
    chk("lsu_lat_rd", bus.write_register, 5'd9);
    chk("lsu_lat_data", bus.write_data, 32'h99);
`endif
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
